// File: rtl/jcb_phase_ctrl_pkg.sv
// Shared types and helpers for the Johnson-counter phase sequencer.
package jcb_phase_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A Johnson code has at most one boundary between adjacent differing bits.
    function automatic logic johnson_legal(input logic [31:0] q, input int unsigned n);
        int unsigned trans;
        trans = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((i + 1 < n) && (q[i] != q[i+1])) begin
                trans++;
            end
        end
        return (trans <= 1);
    endfunction

    // Population count of the low n bits (upper bits are expected to be zero).
    function automatic int unsigned count_ones(input logic [31:0] q);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (q[i]) begin
                ones++;
            end
        end
        return ones;
    endfunction

endpackage

// File: rtl/jcb_phase_ctrl_if.sv
// Host-side control/status bundle of the phase sequencer.
interface jcb_phase_ctrl_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 8
);
    localparam int unsigned IW = $clog2(2 * N);

    logic            start;
    logic [CW-1:0]   cycles;
    logic            pause;
    logic            abort;
    logic            busy;
    logic            done;
    logic [N-1:0]    q;
    logic [2*N-1:0]  phase;
    logic [IW-1:0]   phase_idx;
    logic [CW-1:0]   cnt_left;
    logic            err;

    modport master (
        output start, cycles, pause, abort,
        input  busy, done, q, phase, phase_idx, cnt_left, err
    );

    modport slave (
        input  start, cycles, pause, abort,
        output busy, done, q, phase, phase_idx, cnt_left, err
    );
endinterface

// File: rtl/jcb_phase_ctrl_ring.sv
// N-bit Johnson ring register with step enable and synchronous zero.
module jcb_phase_ctrl_ring #(
    parameter int unsigned N = 4
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_szero,
    output logic [N-1:0] o_q
);
    logic [N-1:0] r_q;

    // Ring state: zeroing wins over stepping.
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_q <= '0;
        end else if (i_szero) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {r_q[N-2:0], ~r_q[N-1]};
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/jcb_phase_ctrl.sv
// Johnson phase sequencer: run control, revolution counter, decode, upset recovery.
module jcb_phase_ctrl
    import jcb_phase_ctrl_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 8
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    jcb_phase_ctrl_if.slave      bus
);
    localparam int unsigned IW = $clog2(2 * N);
    localparam int unsigned PW = 2 * N;
    localparam logic [N-1:0] LAST_CODE = {1'b1, {(N-1){1'b0}}};

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic          w_ring_en;
    logic          w_ring_szero;
    logic [N-1:0]  w_q;
    logic          w_legal;
    logic          w_wrap;
    logic          w_busy;
    logic [IW-1:0] w_idx;
    int unsigned   w_ones;

    jcb_phase_ctrl_ring #(.N(N)) u_ring (
        .i_clk   (i_clk),
        .i_clr   (i_clr),
        .i_en    (w_ring_en),
        .i_szero (w_ring_szero),
        .o_q     (w_q)
    );

    assign w_legal = johnson_legal(32'(w_q), N);
    assign w_wrap  = (w_q == LAST_CODE);

    // State, counter and error registers.
    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, counter and ring control; abort beats upset beats pause.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_ring_en    = 1'b0;
        w_ring_szero = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_err_nxt    = 1'b0;
                    w_ring_szero = 1'b1;
                    if (bus.cycles == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = bus.cycles;
                    end
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                    w_ring_szero = 1'b1;
                end else if (!w_legal) begin
                    w_err_nxt    = 1'b1;
                    w_ring_szero = 1'b1;
                end else if (!bus.pause) begin
                    w_ring_en = 1'b1;
                    if (w_wrap) begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - CW'(1);
                        end
                        if (r_cnt <= CW'(1)) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Phase decode: ones count in the rising half, 2N minus ones in the falling half.
    always_comb begin
        w_ones = count_ones(32'(w_q));
        w_idx  = w_q[N-1] ? IW'(PW - w_ones) : IW'(w_ones);
    end

    assign w_busy        = (r_state == ST_RUN);
    assign bus.busy      = w_busy;
    assign bus.done      = (r_state == ST_DONE);
    assign bus.q         = w_q;
    assign bus.phase_idx = w_busy ? w_idx : '0;
    assign bus.phase     = w_busy ? (PW'(1) << w_idx) : '0;
    assign bus.cnt_left  = r_cnt;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_jcb_phase_ctrl.sv
// Self-checking bench for jcb_phase_ctrl against a phase-counter reference model.
module tb_jcb_phase_ctrl;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    jcb_phase_ctrl_if #(.N(N), .CW(CW)) bus ();

    jcb_phase_ctrl #(.N(N), .CW(CW)) dut (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (bus)
    );

    // Reference model: mode, phase number, revolutions left, error, upset pending.
    int m_mode, m_ph, m_revs;
    bit m_err, m_bad;
    int n_vec, n_bad;
    int edge_no, done_at;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_no);
        end
    endtask

    // Johnson code of phase p: p ones from the bottom, then ones retreating to the top.
    function automatic logic [N-1:0] code_of(input int p);
        logic [31:0] mask;
        mask = (32'd1 << N) - 32'd1;
        if (p <= int'(N)) return N'((32'd1 << p) - 32'd1);
        return N'((mask << (p - int'(N))) & mask);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ph = 0; m_revs = 0; m_err = 1'b0; m_bad = 1'b0;
    endtask

    task automatic model_edge(input bit st, input int cyc, input bit pa, input bit ab);
        case (m_mode)
            M_IDLE: if (st && !ab) begin
                m_err = 1'b0;
                if (cyc == 0) m_mode = M_DONE;
                else begin m_mode = M_RUN; m_ph = 0; m_revs = cyc; end
            end
            M_RUN: begin
                if (ab) begin
                    m_mode = M_IDLE; m_ph = 0; m_revs = 0; m_bad = 1'b0;
                end else if (m_bad) begin
                    m_err = 1'b1; m_ph = 0; m_bad = 1'b0;
                end else if (!pa) begin
                    if (m_ph == 2 * N - 1) begin
                        m_ph = 0;
                        m_revs--;
                        if (m_revs == 0) m_mode = M_DONE;
                    end else begin
                        m_ph++;
                    end
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        bit busy;
        int idx;
        busy = (m_mode == M_RUN);
        // An upset value 0101 decodes to index 2 (two ones, MSB clear).
        idx  = busy ? (m_bad ? 2 : m_ph) : 0;
        check_eq("busy",      32'(bus.busy),      32'(busy));
        check_eq("done",      32'(bus.done),      32'(m_mode == M_DONE));
        check_eq("q",         32'(bus.q),         32'(m_bad ? 4'b0101 : code_of(m_ph)));
        check_eq("phase_idx", 32'(bus.phase_idx), 32'(idx));
        check_eq("phase",     32'(bus.phase),     busy ? (32'd1 << idx) : 32'd0);
        check_eq("cnt_left",  32'(bus.cnt_left),  32'(m_revs));
        check_eq("err",       32'(bus.err),       32'(m_err));
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input bit st, input int cyc, input bit pa, input bit ab);
        bus.start  = st;
        bus.cycles = CW'(cyc);
        bus.pause  = pa;
        bus.abort  = ab;
        @(posedge clk);
        model_edge(st, cyc, pa, ab);
        edge_no++;
        @(negedge clk);
        check_outputs();
        if (bus.done && done_at == 0) done_at = edge_no;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic start_run(input int cyc);
        edge_no = 0;
        done_at = 0;
        step(1'b1, cyc, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; edge_no = 0; done_at = 0;
        bus.start = 1'b0; bus.cycles = '0; bus.pause = 1'b0; bus.abort = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        clr = 1'b1;

        // Two revolutions, nominal timing.
        start_run(2);
        idle_steps(19);
        check_eq("t1_done_edge", 32'(done_at), 32'd17);

        // Zero revolutions: immediate done, never busy.
        start_run(0);
        idle_steps(2);
        check_eq("t2_done_edge", 32'(done_at), 32'd1);

        // Pause three clocks at phase 3.
        start_run(1);
        idle_steps(3);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
        idle_steps(8);
        check_eq("t3_done_edge", 32'(done_at), 32'd12);

        // Abort at phase 5, then restart immediately.
        start_run(3);
        idle_steps(5);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0);
        check_eq("t4_no_done", 32'(done_at), 32'd0);
        start_run(1);
        idle_steps(10);
        check_eq("t4_restart_done", 32'(done_at), 32'd9);

        // Asynchronous clear mid-run at phase 6.
        start_run(2);
        idle_steps(6);
        clr = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        clr = 1'b1;
        start_run(1);
        idle_steps(10);
        check_eq("t5_done_edge", 32'(done_at), 32'd9);

        // Upset in the ring: recovery restarts the revolution.
        start_run(1);
        idle_steps(3);
        force dut.u_ring.r_q = 4'b0101;
        #1;
        release dut.u_ring.r_q;
        m_bad = 1'b1;
        check_outputs();
        idle_steps(11);
        check_eq("t6_done_edge", 32'(done_at), 32'd13);
        check_eq("t6_err_sticky", 32'(bus.err), 32'd1);
        start_run(1);
        check_eq("t6_err_cleared", 32'(bus.err), 32'd0);
        idle_steps(9);

        // Maximum revolution count.
        start_run(255);
        idle_steps(255 * 2 * N + 2);
        check_eq("max_done_edge", 32'(done_at), 32'(255 * 2 * N + 1));

        // Random traffic: starts while busy, pauses, aborts.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
